// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the control pipeline: result source, forward selects
// and the architectural register-index width.
package ctrl_pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Combinational hazard unit: load-use stall, redirect flush and ALU operand
// forwarding selects derived from the E/M/W control state.
module hazard_fwd
  import ctrl_pipe_pkg::*;
(
  input  logic [1:0]       result_src_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_w,
  input  logic [REG_W-1:0] rd_w,
  input  logic             pc_src_e,
  output logic             lw_stall,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b
);

  // The younger producer (Memory) shadows the older one; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             wr_m,
    input logic [REG_W-1:0] dst_m,
    input logic             wr_w,
    input logic [REG_W-1:0] dst_w
  );
    if (wr_m && (dst_m != '0) && (dst_m == rs)) return FWD_MEM;
    if (wr_w && (dst_w != '0) && (dst_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    lw_stall  = (result_src_e == RES_MEM) && (rd_e != '0) &&
                ((rd_e == rs1_d) || (rd_e == rs2_d));
    stall_f   = lw_stall;
    stall_d   = lw_stall;
    flush_d   = pc_src_e;
    flush_e   = lw_stall || pc_src_e;
    forward_a = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    forward_b = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Execute/Memory/Writeback control registers with hazard generation and
// saturating stall/flush event counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              JALRD,
  input  logic              ALUSrcAD,
  input  logic              ALUSrcBD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [REG_W-1:0]  Rs1D,
  input  logic [REG_W-1:0]  Rs2D,
  input  logic [REG_W-1:0]  RdD,
  input  logic              PCSrcE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              JALRE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [REG_W-1:0]  Rs1E,
  output logic [REG_W-1:0]  Rs2E,
  output logic [REG_W-1:0]  RdE,
  output logic              MemWriteM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_W-1:0]  RdW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             MemWriteE;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic [REG_W-1:0] RdM;
  logic             lw_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  hazard_fwd u_hazard (
    .result_src_e (ResultSrcE),
    .rd_e         (RdE),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .rs1_e        (Rs1E),
    .rs2_e        (Rs2E),
    .reg_write_m  (RegWriteM),
    .rd_m         (RdM),
    .reg_write_w  (RegWriteW),
    .rd_w         (RdW),
    .pc_src_e     (PCSrcE),
    .lw_stall     (lw_stall),
    .stall_f      (StallF),
    .stall_d      (StallD),
    .flush_d      (FlushD),
    .flush_e      (FlushE),
    .forward_a    (ForwardAE),
    .forward_b    (ForwardBE)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      JALRE       <= 1'b0;
      ALUSrcAE    <= 1'b0;
      ALUSrcBE    <= 1'b0;
      ALUControlE <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      MemWriteM   <= 1'b0;
      RdM         <= '0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RdW         <= '0;
      StallCount  <= '0;
      FlushCount  <= '0;
    end else begin
      // Decode -> Execute: a flush inserts the all-zero bubble
      if (FlushE) begin
        RegWriteE   <= 1'b0;
        ResultSrcE  <= 2'b00;
        MemWriteE   <= 1'b0;
        BranchE     <= 1'b0;
        JumpE       <= 1'b0;
        JALRE       <= 1'b0;
        ALUSrcAE    <= 1'b0;
        ALUSrcBE    <= 1'b0;
        ALUControlE <= '0;
        Rs1E        <= '0;
        Rs2E        <= '0;
        RdE         <= '0;
      end else begin
        RegWriteE   <= RegWriteD;
        ResultSrcE  <= ResultSrcD;
        MemWriteE   <= MemWriteD;
        BranchE     <= BranchD;
        JumpE       <= JumpD;
        JALRE       <= JALRD;
        ALUSrcAE    <= ALUSrcAD;
        ALUSrcBE    <= ALUSrcBD;
        ALUControlE <= ALUControlD;
        Rs1E        <= Rs1D;
        Rs2E        <= Rs2D;
        RdE         <= RdD;
      end
      // Execute -> Memory
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      RdM        <= RdE;
      // Memory -> Writeback
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      if (lw_stall) StallCount <= sat_inc(StallCount);
      if (PCSrcE)   FlushCount <= sat_inc(FlushCount);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a history-list model checked every cycle plus
// hand-computed literal checks at key points of each scenario.
module tb_ctrl_pipe;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       br;
    logic       jp;
    logic       jalr;
    logic       sa;
    logic       sb;
    logic [2:0] aluc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } bnd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic pcsrc;
  bnd_t d;

  logic          ALUSrcAE, ALUSrcBE, BranchE, JumpE, JALRE;
  logic [2:0]    ALUControlE;
  logic [4:0]    Rs1E, Rs2E, RdE, RdW;
  logic          MemWriteM, RegWriteW;
  logic [1:0]    ResultSrcW, ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [CW-1:0] StallCount, FlushCount;

  ctrl_pipe #(.ALUC_W(3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(d.rw), .ResultSrcD(d.rs), .MemWriteD(d.mw), .BranchD(d.br),
    .JumpD(d.jp), .JALRD(d.jalr), .ALUSrcAD(d.sa), .ALUSrcBD(d.sb),
    .ALUControlD(d.aluc), .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .PCSrcE(pcsrc),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .BranchE(BranchE), .JumpE(JumpE),
    .JALRE(JALRE), .ALUControlE(ALUControlE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  int tests = 0;
  int fails = 0;
  bit en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // hist[0] is the instruction in Execute, hist[1] in Memory, hist[2] in Writeback
  bnd_t hist [3];
  int   m_sc, m_fc;
  logic exp_lw;

  function automatic logic [1:0] exp_fwd(input logic [4:0] src, input bnd_t m, input bnd_t w);
    if (m.rw && m.rd != 0 && m.rd == src) return 2'b10;
    if (w.rw && w.rd != 0 && w.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  always_comb
    exp_lw = (hist[0].rs == 2'b01) && (hist[0].rd != 0) &&
             ((hist[0].rd == d.rs1) || (hist[0].rd == d.rs2));

  always @(posedge clk) begin
    if (reset) begin
      hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
      m_sc <= 0; m_fc <= 0;
    end else begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= (exp_lw || pcsrc) ? '0 : d;
      if (exp_lw) m_sc <= (m_sc == CMAX) ? m_sc : m_sc + 1;
      if (pcsrc)  m_fc <= (m_fc == CMAX) ? m_fc : m_fc + 1;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("ALUSrcAE", ALUSrcAE, hist[0].sa);
      chk("ALUSrcBE", ALUSrcBE, hist[0].sb);
      chk("BranchE", BranchE, hist[0].br);
      chk("JumpE", JumpE, hist[0].jp);
      chk("JALRE", JALRE, hist[0].jalr);
      chk("ALUControlE", ALUControlE, hist[0].aluc);
      chk("Rs1E", Rs1E, hist[0].rs1);
      chk("Rs2E", Rs2E, hist[0].rs2);
      chk("RdE", RdE, hist[0].rd);
      chk("MemWriteM", MemWriteM, hist[1].mw);
      chk("RegWriteW", RegWriteW, hist[2].rw);
      chk("ResultSrcW", ResultSrcW, hist[2].rs);
      chk("RdW", RdW, hist[2].rd);
      chk("ForwardAE", ForwardAE, exp_fwd(hist[0].rs1, hist[1], hist[2]));
      chk("ForwardBE", ForwardBE, exp_fwd(hist[0].rs2, hist[1], hist[2]));
      chk("StallF", StallF, exp_lw);
      chk("StallD", StallD, exp_lw);
      chk("FlushD", FlushD, pcsrc);
      chk("FlushE", FlushE, exp_lw || pcsrc);
      chk("StallCount", StallCount, m_sc);
      chk("FlushCount", FlushCount, m_fc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic bnd_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bnd_t b;
    b      = '0;
    b.rw   = rw;
    b.rs   = rs;
    b.mw   = mw;
    b.rd   = rd;
    b.rs1  = rs1;
    b.rs2  = rs2;
    b.aluc = rd[2:0];
    b.sa   = rs1[0];
    b.sb   = rs2[0];
    return b;
  endfunction

  initial begin
    reset = 1'b1;
    pcsrc = 1'b0;
    d     = '0;
    cyc();
    en = 1'b1;
    cyc();
    reset = 1'b0;

    // reset state and R-type latency of three cycles
    at_neg();
    chk("rst_StallF", StallF, 0);
    chk("rst_FlushE", FlushE, 0);
    chk("rst_StallCount", StallCount, 0);
    chk("rst_RegWriteW", RegWriteW, 0);
    cyc();
    d = mk(1, 2'b00, 0, 5'd5, 5'd1, 5'd2);
    cyc();
    d = '0;
    cyc();
    at_neg();
    chk("rtype_W_early", RegWriteW, 0);
    cyc();
    at_neg();
    chk("rtype_RegWriteW", RegWriteW, 1);
    chk("rtype_RdW", RdW, 5);
    chk("rtype_MemWriteM", MemWriteM, 0);
    cyc();

    // load-use: one stall cycle, bubble in E, then Writeback forwarding
    d = mk(1, 2'b01, 0, 5'd7, 5'd2, 5'd0);
    cyc();
    d = mk(1, 2'b00, 0, 5'd8, 5'd7, 5'd0);
    at_neg();
    chk("lu_StallF", StallF, 1);
    chk("lu_StallD", StallD, 1);
    chk("lu_FlushE", FlushE, 1);
    cyc();
    at_neg();
    chk("lu_bubble_RdE", RdE, 0);
    chk("lu_bubble_Rs1E", Rs1E, 0);
    cyc();
    d = '0;
    at_neg();
    chk("lu_Rs1E", Rs1E, 7);
    chk("lu_ForwardAE", ForwardAE, 2'b01);
    chk("lu_StallCount", StallCount, 1);
    cyc(); cyc();

    // back-to-back: Memory forwarding
    d = mk(1, 2'b00, 0, 5'd3, 5'd1, 5'd1);
    cyc();
    d = mk(1, 2'b00, 0, 5'd9, 5'd3, 5'd3);
    cyc();
    d = '0;
    at_neg();
    chk("b2b_ForwardAE", ForwardAE, 2'b10);
    chk("b2b_ForwardBE", ForwardBE, 2'b10);
    cyc(); cyc();

    // two apart: Writeback forwarding
    d = mk(1, 2'b00, 0, 5'd3, 5'd1, 5'd1);
    cyc();
    d = mk(1, 2'b00, 0, 5'd4, 5'd1, 5'd2);
    cyc();
    d = mk(1, 2'b00, 0, 5'd9, 5'd3, 5'd3);
    cyc();
    d = '0;
    at_neg();
    chk("gap_ForwardAE", ForwardAE, 2'b01);
    chk("gap_ForwardBE", ForwardBE, 2'b01);
    cyc(); cyc();

    // both older instructions write x3: Memory wins
    d = mk(1, 2'b00, 0, 5'd3, 5'd1, 5'd1);
    cyc();
    d = mk(1, 2'b00, 0, 5'd3, 5'd2, 5'd2);
    cyc();
    d = mk(1, 2'b00, 0, 5'd9, 5'd3, 5'd3);
    cyc();
    d = '0;
    at_neg();
    chk("prio_ForwardAE", ForwardAE, 2'b10);
    chk("prio_ForwardBE", ForwardBE, 2'b10);
    cyc(); cyc();

    // x0 destination: load to x0 never stalls or forwards
    d = mk(1, 2'b01, 0, 5'd0, 5'd1, 5'd2);
    cyc();
    d = mk(1, 2'b00, 0, 5'd10, 5'd0, 5'd0);
    at_neg();
    chk("x0_StallF", StallF, 0);
    cyc();
    d = '0;
    at_neg();
    chk("x0_ForwardAE", ForwardAE, 2'b00);
    chk("x0_ForwardBE", ForwardBE, 2'b00);
    cyc(); cyc();

    // redirect coinciding with load-use stall
    d = mk(1, 2'b01, 0, 5'd7, 5'd1, 5'd2);
    cyc();
    d = mk(1, 2'b00, 0, 5'd11, 5'd7, 5'd0);
    d.jp = 1'b1;
    pcsrc = 1'b1;
    at_neg();
    chk("rd_FlushD", FlushD, 1);
    chk("rd_FlushE", FlushE, 1);
    chk("rd_StallD", StallD, 1);
    cyc();
    pcsrc = 1'b0;
    d = '0;
    at_neg();
    chk("rd_bubble_RdE", RdE, 0);
    chk("rd_bubble_JumpE", JumpE, 0);
    chk("rd_StallCount", StallCount, 2);
    chk("rd_FlushCount", FlushCount, 1);
    cyc(); cyc();

    // reset with valid bundles in every stage
    d = mk(1, 2'b10, 1, 5'd12, 5'd13, 5'd14);
    d.br = 1'b1;
    cyc(); cyc(); cyc();
    at_neg();
    chk("full_MemWriteM", MemWriteM, 1);
    chk("full_RegWriteW", RegWriteW, 1);
    reset = 1'b1;
    pcsrc = 1'b1;
    cyc();
    reset = 1'b0;
    pcsrc = 1'b0;
    at_neg();
    chk("mid_rst_RdE", RdE, 0);
    chk("mid_rst_BranchE", BranchE, 0);
    chk("mid_rst_MemWriteM", MemWriteM, 0);
    chk("mid_rst_RegWriteW", RegWriteW, 0);
    chk("mid_rst_RdW", RdW, 0);
    chk("mid_rst_FlushCount", FlushCount, 0);
    chk("mid_rst_StallCount", StallCount, 0);
    d = '0;
    cyc(); cyc(); cyc();

    // saturation of both counters at all-ones
    pcsrc = 1'b1;
    repeat (20) cyc();
    pcsrc = 1'b0;
    at_neg();
    chk("sat_FlushCount", FlushCount, 15);
    for (int i = 0; i < 20; i++) begin
      d = mk(1, 2'b01, 0, 5'd7, 5'd1, 5'd2);
      cyc();
      d = mk(1, 2'b00, 0, 5'd8, 5'd7, 5'd0);
      cyc();
    end
    d = '0;
    cyc();
    at_neg();
    chk("sat_StallCount", StallCount, 15);
    chk("sat_FlushCount_hold", FlushCount, 15);
    cyc();

    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumes the decoded control bundle produced in Decode and carries it through the Execute, Memory and Writeback control registers.
- Generates the hazard-side controls from that bundle: load-use stall, branch/jump flush, and ALU operand forwarding selects.
- Sits between the main/ALU decoders and the datapath pipeline registers; it owns no datapath values.
- Also keeps saturating stall and flush event counters for performance debug.

Parameters:
- ALUC_W, 3, width of ALUControl.
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clk in 1 system clock, all state updates on rising edge.
- reset in 1 synchronous, active-high reset.
- RegWriteD in 1; ResultSrcD in 2; MemWriteD in 1; BranchD in 1; JumpD in 1; JALRD in 1; ALUSrcAD in 1; ALUSrcBD in 1: decoded controls from Decode.
- ALUControlD in ALUC_W ALU operation from Decode.
- Rs1D, Rs2D, RdD in 5 each: register indices of the Decode instruction.
- PCSrcE in 1 branch taken or jump, resolved in Execute.
- ALUSrcAE, ALUSrcBE, BranchE, JumpE, JALRE out 1 each: Execute-stage controls.
- ALUControlE out ALUC_W.
- Rs1E, Rs2E, RdE out 5 each.
- MemWriteM out 1.
- RegWriteW out 1; ResultSrcW out 2; RdW out 5.
- ForwardAE, ForwardBE out 2 each: 00 register file, 10 Memory ALU result, 01 Writeback result.
- StallF, StallD, FlushD, FlushE out 1 each.
- StallCount, FlushCount out CNT_W each.

Behaviour:
- Pipeline registers:
  - E stage holds the full D bundle.
  - M stage holds RegWrite, ResultSrc, MemWrite and Rd.
  - W stage holds RegWrite, ResultSrc and Rd.
  - Each stage advances by one cycle per clock; D-to-W latency is 3 cycles.
- Reset (synchronous, active-high): every E/M/W register, both counters and all registered outputs are 0. Combinational outputs follow from the zeroed state, so StallF, StallD, FlushD and FlushE are all 0 in the cycle after reset.
- Bubble definition: all control bits 0 and Rd/Rs = 0. This matches the all-zero control row for opcode 0, so a bubble writes nothing and stores nothing.
- Load-use stall (combinational):
  - lwStall = (ResultSrcE == 01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - Rs2D is compared for every opcode; this is intentionally conservative.
- Hazard outputs (combinational):
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- E-stage update: when FlushE = 1, the E registers load a bubble; otherwise they load the D inputs.
- M and W never stall or flush; they always advance.
- Stall and redirect in the same cycle: FlushE = 1 and FlushD = 1 while StallF and StallD also stay 1. The redirect wins at the datapath level because the D instruction is flushed. Count this as one stall event and one flush event.
- ForwardAE (combinational):
  - 10 if RegWriteM & (RdM != 0) & (RdM == Rs1E).
  - else 01 if RegWriteW & (RdW != 0) & (RdW == Rs1E).
  - else 00.
  - Memory takes priority over Writeback when both match.
- ForwardBE: identical rule using Rs2E.
- x0 is never forwarded: Rd = 0 always yields 00.
- Counters:
  - StallCount increments in every cycle where lwStall = 1.
  - FlushCount increments in every cycle where PCSrcE = 1.
  - Both saturate at all-ones (no wrap) and clear only on reset.
- Reset asserted mid-stream: on the next edge the whole pipe holds bubbles regardless of the D inputs. Inputs presented during reset are discarded.

Decomposition:
- Shared package holds:
  - ResultSrc encodings: RES_ALU = 00, RES_MEM = 01, RES_PC4 = 10.
  - Forward encodings: FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10.
  - The 5-bit register-index width.
- One natural sub-module, hazard_fwd: purely combinational lwStall, flush and forward logic.
- The stage registers and counters stay in ctrl_pipe.

Test Plan:
1. Reset, then present an R-type bundle (RegWriteD = 1, RdD = 5) -> RegWriteW = 1 and RdW = 5 exactly 3 cycles later; MemWriteM = 0; all stall/flush outputs 0.
2. Load with RdD = 7, then next cycle Rs1D = 7 -> one cycle with StallF = StallD = FlushE = 1 and E holding a bubble. On the following cycle Rs1E = 7, ForwardAE = 01 once the load reaches W. StallCount = 1.
3. Back-to-back R-types: write x3, then read Rs1D = 3 and Rs2D = 3 -> ForwardAE = ForwardBE = 10. If x3 is written two instructions earlier, both selects = 01. If both older instructions write x3, 10 wins.
4. Writer with RdD = 0 followed by reader with Rs1D = 0 -> ForwardAE = 00 and no stall, including when ResultSrcE = 01.
5. PCSrcE = 1 coinciding with lwStall -> FlushD = FlushE = 1 and StallD = 1. E becomes a bubble next cycle; StallCount and FlushCount each +1.
6. Assert reset with a valid bundle in every stage -> next cycle all outputs 0 and counters 0. Separately, preload FlushCount to all-ones via long toggling (or a CNT_W = 4 build) -> the counter holds at 15.
